// File: rtl/washing_phase_timer.sv
// Phase timer for the washing_machine controller: times each commanded phase
// from a duration table and drives the controller's *_done levels.
module washing_phase_timer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_water,
  input  logic             wash,
  input  logic             rinse,
  input  logic             spin,
  input  logic             drain,
  input  logic             dry,
  input  logic             pause,
  input  logic [1:0]       temp_select,
  input  logic [1:0]       cloth_type,
  input  logic [1:0]       cycle_duration,
  output logic             fill_done,
  output logic             wash_done,
  output logic             rinse_done,
  output logic             spin_done,
  output logic             drain_done,
  output logic             dry_done,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       phase_id,
  output logic             multi_cmd_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  localparam logic [2:0] PH_NONE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;
  localparam logic [2:0] PH_DRAIN = 3'd5;
  localparam logic [2:0] PH_DRY   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [5:0]       done_q, done_d;
  logic             err_q;

  logic [5:0]       cmds;
  logic [2:0]       sel_phase;
  logic             any_cmd;

  // Durations are formed in 32 bits and clamped to the counter width.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [31:0] v);
    if ({32'd0, v} > CNT_MAX) return {CNT_W{1'b1}};
    return CNT_W'(v);
  endfunction

  function automatic logic [2:0] select_phase(input logic [5:0] c);
    if (c[0]) return PH_FILL;
    if (c[1]) return PH_WASH;
    if (c[2]) return PH_RINSE;
    if (c[3]) return PH_SPIN;
    if (c[4]) return PH_DRAIN;
    if (c[5]) return PH_DRY;
    return PH_NONE;
  endfunction

  function automatic logic [CNT_W-1:0] phase_dur(input logic [2:0] ph,
                                                 input logic [1:0] cyc,
                                                 input logic [1:0] tmp,
                                                 input logic [1:0] cloth);
    logic [31:0] d;
    d = 32'd0;
    case (ph)
      PH_FILL:  d = 32'd8;
      PH_WASH:  d = ((32'(cyc) + 32'd1) << 4) + (32'(tmp) << 2);
      PH_RINSE: d = 32'd8;
      PH_SPIN: begin
        case (cloth)
          2'b00:   d = 32'd8;
          2'b11:   d = 32'd2;
          default: d = 32'd4;
        endcase
      end
      PH_DRAIN: d = 32'd4;
      PH_DRY:   d = cloth[1] ? 32'd6 : 32'd12;
      default:  d = 32'd0;
    endcase
    return sat_cnt(d);
  endfunction

  function automatic logic [5:0] done_mask(input logic [2:0] ph);
    case (ph)
      PH_FILL:  return 6'b000001;
      PH_WASH:  return 6'b000010;
      PH_RINSE: return 6'b000100;
      PH_SPIN:  return 6'b001000;
      PH_DRAIN: return 6'b010000;
      PH_DRY:   return 6'b100000;
      default:  return 6'b000000;
    endcase
  endfunction

  assign cmds      = {dry, drain, spin, rinse, wash, fill_water};
  assign sel_phase = select_phase(cmds);
  assign any_cmd   = |cmds;

  // Abort / phase-change checks outrank pause and the tick countdown.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    done_d  = 6'b000000;
    case (state_q)
      IDLE: begin
        rem_d   = '0;
        phase_d = PH_NONE;
        presc_d = '0;
        if (any_cmd) begin
          state_d = LOAD;
          phase_d = sel_phase;
        end
      end
      default: begin
        if (!any_cmd) begin
          state_d = IDLE;
          phase_d = PH_NONE;
          rem_d   = '0;
          presc_d = '0;
        end else if (sel_phase != phase_q) begin
          state_d = LOAD;
          phase_d = sel_phase;
          rem_d   = '0;
          presc_d = '0;
        end else begin
          case (state_q)
            LOAD: begin
              state_d = RUN;
              rem_d   = phase_dur(phase_q, cycle_duration, temp_select, cloth_type);
              presc_d = '0;
            end
            RUN: begin
              if (!pause) begin
                if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  rem_d   = rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = done_mask(phase_q);
                  end
                end else begin
                  presc_d = presc_q + PW'(1);
                end
              end
            end
            DONE: done_d = done_mask(phase_q);
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_NONE;
      rem_q   <= '0;
      presc_q <= '0;
      done_q  <= 6'b000000;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      err_q   <= ($countones(cmds) > 1);
    end
  end

  assign fill_done     = done_q[0];
  assign wash_done     = done_q[1];
  assign rinse_done    = done_q[2];
  assign spin_done     = done_q[3];
  assign drain_done    = done_q[4];
  assign dry_done      = done_q[5];
  assign remaining     = rem_q;
  assign phase_id      = phase_q;
  assign multi_cmd_err = err_q;

  a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(done_q));
  a_done_only_in_done: assert property (@(posedge clk) disable iff (reset)
                                        (done_q != 6'b000000) |-> (state_q == DONE));

endmodule

// File: tb/tb_washing_phase_timer.sv
// Randomized and directed bench for washing_phase_timer against an elapsed-time
// reference model of the phase rules.
module tb_washing_phase_timer;
  localparam int TD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fill_water = 1'b0, wash = 1'b0, rinse = 1'b0;
  logic          spin = 1'b0, drain = 1'b0, dry = 1'b0, pause = 1'b0;
  logic [1:0]    temp_select = 2'd0, cloth_type = 2'd0, cycle_duration = 2'd0;
  logic          fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done;
  logic [CW-1:0] remaining;
  logic [2:0]    phase_id;
  logic          multi_cmd_err;
  logic [5:0]    dv;
  logic [5:0]    cmd_vec;

  washing_phase_timer #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .fill_water(fill_water), .wash(wash), .rinse(rinse),
    .spin(spin), .drain(drain), .dry(dry), .pause(pause),
    .temp_select(temp_select), .cloth_type(cloth_type), .cycle_duration(cycle_duration),
    .fill_done(fill_done), .wash_done(wash_done), .rinse_done(rinse_done),
    .spin_done(spin_done), .drain_done(drain_done), .dry_done(dry_done),
    .remaining(remaining), .phase_id(phase_id), .multi_cmd_err(multi_cmd_err)
  );

  always #5 clk = ~clk;

  assign dv      = {dry_done, drain_done, spin_done, rinse_done, wash_done, fill_done};
  assign cmd_vec = {dry, drain, spin, rinse, wash, fill_water};

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit model_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the phase is described by how many un-paused tick clocks
  // have elapsed since its duration was loaded.
  typedef struct {
    int phase;
    bit load;
    int d;
    int act;
    bit err;
  } model_t;

  model_t m;

  function automatic int prio(input logic [5:0] c);
    for (int i = 0; i < 6; i++) if (c[i]) return i + 1;
    return 0;
  endfunction

  function automatic int dur(input int ph, input int cd, input int tp, input int cl);
    int spin_t[4];
    int dry_t[4];
    spin_t = '{8, 4, 4, 2};
    dry_t  = '{12, 12, 6, 6};
    case (ph)
      1: return 8;
      2: return 16 * (cd + 1) + 4 * tp;
      3: return 8;
      4: return spin_t[cl];
      5: return 4;
      6: return dry_t[cl];
      default: return 0;
    endcase
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [5:0] c, input logic p,
                                        input logic [1:0] cd, input logic [1:0] tp,
                                        input logic [1:0] cl);
    model_t n;
    int sel;
    n   = cur;
    sel = prio(c);
    n.err = ($countones(c) >= 2);
    if (sel == 0) begin
      n.phase = 0; n.load = 1'b0; n.d = 0; n.act = 0;
    end else if (sel != cur.phase) begin
      n.phase = sel; n.load = 1'b1; n.d = 0; n.act = 0;
    end else if (cur.load) begin
      n.load = 1'b0; n.d = dur(sel, int'(cd), int'(tp), int'(cl)); n.act = 0;
    end else if (!p && cur.act < cur.d * TD) begin
      n.act = cur.act + 1;
    end
    return n;
  endfunction

  function automatic int exp_rem(input model_t x);
    return x.d - x.act / TD;
  endfunction

  function automatic logic [5:0] exp_done(input model_t x);
    logic [5:0] one;
    one = 6'd1;
    if (x.phase != 0 && !x.load && x.d > 0 && x.act == x.d * TD) return one << (x.phase - 1);
    return 6'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{default: 0};
    else       m <= model_next(m, cmd_vec, pause, cycle_duration, temp_select, cloth_type);
  end

  always @(negedge clk) begin
    if (model_chk && !reset) begin
      check("model_phase_id", phase_id, m.phase);
      check("model_remaining", remaining, exp_rem(m));
      check("model_done", dv, exp_done(m));
      check("model_multi_err", multi_cmd_err, m.err);
    end
  end

  task automatic set_cmd(input logic [5:0] c);
    {dry, drain, spin, rinse, wash, fill_water} = c;
  endtask

  task automatic idle_cycles(input int n);
    set_cmd(6'd0);
    repeat (n) @(negedge clk);
  endtask

  // Latency is counted from the first edge that samples the command.
  task automatic wait_done(input int bitn, input int start, input int lim, output int lat);
    lat = -1;
    while (cyc - start <= lim) begin
      @(negedge clk);
      if (dv[bitn]) begin
        lat = cyc - start - 1;
        break;
      end
    end
  endtask

  initial begin
    int start;
    int lat;
    int r0;
    bit found;
    logic [5:0] one;
    one = 6'd1;

    #1 reset = 1'b1;
    #1;
    check("reset_phase_id", phase_id, 0);
    check("reset_remaining", remaining, 0);
    check("reset_done", dv, 0);
    check("reset_multi_err", multi_cmd_err, 0);
    @(negedge clk);
    reset = 1'b0;
    model_chk = 1'b1;
    idle_cycles(3);

    // Fill, cotton
    start = cyc;
    set_cmd(6'b000001);
    wait_done(0, start, 200, lat);
    check("fill_latency", lat, 33);
    check("fill_remaining", remaining, 0);
    check("fill_phase_id", phase_id, 1);
    set_cmd(6'd0);
    @(negedge clk);
    check("fill_drop", fill_done, 0);

    // Wash D=40, cycle_duration changed mid-run
    idle_cycles(2);
    cycle_duration = 2'd1;
    temp_select    = 2'd2;
    start = cyc;
    set_cmd(6'b000010);
    repeat (50) @(negedge clk);
    cycle_duration = 2'd3;
    wait_done(1, start, 400, lat);
    check("wash_latency", lat, 161);

    // Pause mid-wash for 10 cycles
    idle_cycles(2);
    cycle_duration = 2'd1;
    start = cyc;
    set_cmd(6'b000010);
    repeat (20) @(negedge clk);
    r0 = int'(remaining);
    check("wash_rem_before_pause", r0, 36);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_hold", remaining, r0);
    end
    pause = 1'b0;
    wait_done(1, start, 400, lat);
    check("pause_latency", lat, 171);

    // Abort spin at remaining=3
    idle_cycles(2);
    cloth_type = 2'd0;
    set_cmd(6'b001000);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (remaining == 3 && phase_id == 3'd4) found = 1'b1;
    end
    check("abort_reached_rem3", found, 1);
    set_cmd(6'd0);
    @(negedge clk);
    check("abort_phase_id", phase_id, 0);
    check("abort_remaining", remaining, 0);
    check("abort_spin_done", spin_done, 0);
    repeat (40) @(negedge clk);
    check("abort_spin_done_late", spin_done, 0);

    // Overlap fill+dry, then dry alone (cotton D=12)
    idle_cycles(2);
    set_cmd(6'b100001);
    @(negedge clk);
    check("overlap_multi_err", multi_cmd_err, 1);
    check("overlap_phase_id", phase_id, 1);
    repeat (4) @(negedge clk);
    start = cyc;
    set_cmd(6'b100000);
    @(negedge clk);
    check("overlap_dry_phase_id", phase_id, 6);
    check("overlap_multi_clear", multi_cmd_err, 0);
    wait_done(5, start, 300, lat);
    check("dry_latency", lat, 49);

    // Asynchronous reset mid-rinse, restart from scratch
    idle_cycles(2);
    set_cmd(6'b000100);
    repeat (20) @(negedge clk);
    check("rinse_rem_before_reset", remaining, 4);
    #2 reset = 1'b1;
    #1;
    check("async_reset_phase_id", phase_id, 0);
    check("async_reset_remaining", remaining, 0);
    check("async_reset_done", dv, 0);
    check("async_reset_multi_err", multi_cmd_err, 0);
    @(negedge clk);
    reset = 1'b0;
    start = cyc;
    wait_done(2, start, 200, lat);
    check("rinse_after_reset_latency", lat, 33);

    // Randomized traffic against the model
    set_cmd(6'd0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0 || (dv != 6'd0 && $urandom_range(0, 3) == 0)) begin
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0)      set_cmd(6'd0);
        else if (r == 7) set_cmd(6'($urandom));
        else             set_cmd(one << (r - 1));
      end
      if ($urandom_range(0, 7) == 0) begin
        temp_select    = 2'($urandom);
        cloth_type     = 2'($urandom);
        cycle_duration = 2'($urandom);
      end
      pause = ($urandom_range(0, 7) == 0);
    end

    model_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
